// File: rtl/midi_voice_alloc.sv
// MIDI byte-stream parser and voice-slot allocator feeding the synth core.
// Note messages drive a one-slot-per-cycle scan of the voice table; pitch bend bypasses it.
module midi_voice_alloc #(
   parameter int NUM_VOICES = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       rx_ready,
   output logic       note_pressed,
   output logic       note_released,
   output logic       note_keypress,
   output logic       pitch_wheel,
   output logic [6:0] note,
   output logic [6:0] velocity,
   output logic [3:0] channel,
   output logic [7:0] addr,
   output logic       voice_overflow
);
   localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_RESULT} state_t;
   typedef enum logic [1:0] {MSG_ON, MSG_OFF, MSG_AT} msg_t;

   state_t state_reg, state_next;

   // parser state
   logic       accept;
   logic       status_valid_reg;
   logic [2:0] status_type_reg;
   logic [3:0] status_chan_reg;
   logic       data_cnt_reg;
   logic [6:0] data0_reg;
   logic       msg_done;
   logic       scan_start;
   logic       pitch_done;
   msg_t       start_kind;

   // latched message under scan
   msg_t       msg_kind_reg;
   logic [3:0] msg_chan_reg;
   logic [6:0] msg_note_reg;
   logic [6:0] msg_vel_reg;

   // scan bookkeeping
   logic [IDX_W-1:0] scan_idx_reg;
   logic             found_match_reg;
   logic [IDX_W-1:0] match_idx_reg;
   logic             found_free_reg;
   logic [IDX_W-1:0] free_idx_reg;

   // voice table: {channel, note} in RAM, active flags in flops so reset can clear them at once
   logic [10:0]           table_mem [NUM_VOICES];
   logic [10:0]           rd_data_reg;
   logic [IDX_W-1:0]      rd_addr;
   logic [NUM_VOICES-1:0] active_reg;
   logic [NUM_VOICES-1:0] active_next;

   logic             cur_active;
   logic             match_hit;
   logic             free_hit;
   logic             result_en;
   logic             fin_match;
   logic             fin_free;
   logic [IDX_W-1:0] fin_match_idx;
   logic [IDX_W-1:0] fin_free_idx;
   logic [IDX_W-1:0] event_idx;
   logic             do_press;
   logic             do_release;
   logic             do_keypress;
   logic             do_overflow;
   logic             set_en;
   logic             clr_en;

   logic       note_pressed_reg;
   logic       note_released_reg;
   logic       note_keypress_reg;
   logic       pitch_wheel_reg;
   logic       voice_overflow_reg;
   logic [6:0] note_reg;
   logic [6:0] velocity_reg;
   logic [3:0] channel_reg;
   logic [7:0] addr_reg;

   // FSM: state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // FSM: next state
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:   if (scan_start) state_next = ST_SCAN;
         ST_SCAN:   if (scan_idx_reg == LAST_IDX) state_next = ST_RESULT;
         ST_RESULT: state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   // FSM: outputs; read address runs one slot ahead to cover the RAM read latency
   always_comb begin
      rx_ready = (state_reg == ST_IDLE);
      rd_addr  = '0;
      if (state_reg == ST_SCAN && scan_idx_reg != LAST_IDX) begin
         rd_addr = scan_idx_reg + 1'b1;
      end
   end

   always_comb begin
      accept     = rx_valid && rx_ready;
      msg_done   = accept && !rx_data[7] && status_valid_reg &&
                   (data_cnt_reg || status_type_reg[2:1] == 2'b10);
      scan_start = msg_done && !status_type_reg[2] && status_type_reg[1:0] != 2'b11;
      pitch_done = msg_done && status_type_reg == 3'b110;
      case (status_type_reg[1:0])
         2'b00:   start_kind = MSG_OFF;
         2'b01:   start_kind = (rx_data[6:0] == 7'd0) ? MSG_OFF : MSG_ON;
         default: start_kind = MSG_AT;
      endcase
   end

   // Realtime bytes (F8-FF) leave running status and partial data untouched.
   always_ff @(posedge clk) begin
      if (rst) begin
         status_valid_reg <= 1'b0;
         status_type_reg  <= 3'd0;
         status_chan_reg  <= 4'd0;
         data_cnt_reg     <= 1'b0;
         data0_reg        <= 7'd0;
      end else if (accept) begin
         if (rx_data[7]) begin
            if (rx_data[7:3] != 5'b11111) begin
               status_valid_reg <= (rx_data[7:4] != 4'hF);
               status_type_reg  <= rx_data[6:4];
               status_chan_reg  <= rx_data[3:0];
               data_cnt_reg     <= 1'b0;
            end
         end else if (status_valid_reg) begin
            if (msg_done) begin
               data_cnt_reg <= 1'b0;
            end else begin
               data_cnt_reg <= 1'b1;
               data0_reg    <= rx_data[6:0];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         msg_kind_reg    <= MSG_ON;
         msg_chan_reg    <= 4'd0;
         msg_note_reg    <= 7'd0;
         msg_vel_reg     <= 7'd0;
         scan_idx_reg    <= '0;
         found_match_reg <= 1'b0;
         match_idx_reg   <= '0;
         found_free_reg  <= 1'b0;
         free_idx_reg    <= '0;
      end else if (scan_start) begin
         msg_kind_reg    <= start_kind;
         msg_chan_reg    <= status_chan_reg;
         msg_note_reg    <= data0_reg;
         msg_vel_reg     <= rx_data[6:0];
         scan_idx_reg    <= '0;
         found_match_reg <= 1'b0;
         found_free_reg  <= 1'b0;
      end else if (state_reg == ST_SCAN) begin
         scan_idx_reg <= rd_addr;
         if (match_hit && !found_match_reg) begin
            found_match_reg <= 1'b1;
            match_idx_reg   <= scan_idx_reg;
         end
         if (free_hit && !found_free_reg) begin
            found_free_reg <= 1'b1;
            free_idx_reg   <= scan_idx_reg;
         end
      end
   end

   // The last scan cycle folds in its own slot so the result lands exactly one cycle later.
   always_comb begin
      cur_active    = active_reg[scan_idx_reg];
      match_hit     = cur_active && (rd_data_reg == {msg_chan_reg, msg_note_reg});
      free_hit      = !cur_active;
      result_en     = (state_reg == ST_SCAN) && (scan_idx_reg == LAST_IDX);
      fin_match     = found_match_reg || match_hit;
      fin_match_idx = found_match_reg ? match_idx_reg : scan_idx_reg;
      fin_free      = found_free_reg || free_hit;
      fin_free_idx  = found_free_reg ? free_idx_reg : scan_idx_reg;
      event_idx     = fin_match ? fin_match_idx : fin_free_idx;
      do_press      = result_en && msg_kind_reg == MSG_ON && (fin_match || fin_free);
      set_en        = result_en && msg_kind_reg == MSG_ON && !fin_match && fin_free;
      do_overflow   = result_en && msg_kind_reg == MSG_ON && !fin_match && !fin_free;
      do_release    = result_en && msg_kind_reg == MSG_OFF && fin_match;
      do_keypress   = result_en && msg_kind_reg == MSG_AT && fin_match;
      clr_en        = do_release;
   end

   always_ff @(posedge clk) begin
      if (set_en) begin
         table_mem[fin_free_idx] <= {msg_chan_reg, msg_note_reg};
      end
      rd_data_reg <= table_mem[rd_addr];
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_VOICES; gi++) begin : g_slot
         assign active_next[gi] = (set_en && fin_free_idx == IDX_W'(gi)) ? 1'b1 :
                                  (clr_en && fin_match_idx == IDX_W'(gi)) ? 1'b0 :
                                  active_reg[gi];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         active_reg <= '0;
      end else begin
         active_reg <= active_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         note_pressed_reg   <= 1'b0;
         note_released_reg  <= 1'b0;
         note_keypress_reg  <= 1'b0;
         pitch_wheel_reg    <= 1'b0;
         voice_overflow_reg <= 1'b0;
         note_reg           <= 7'd0;
         velocity_reg       <= 7'd0;
         channel_reg        <= 4'd0;
         addr_reg           <= 8'd0;
      end else begin
         note_pressed_reg   <= do_press;
         note_released_reg  <= do_release;
         note_keypress_reg  <= do_keypress;
         pitch_wheel_reg    <= pitch_done;
         voice_overflow_reg <= do_overflow;
         if (do_press || do_release || do_keypress) begin
            note_reg     <= msg_note_reg;
            velocity_reg <= msg_vel_reg;
            channel_reg  <= msg_chan_reg;
            addr_reg     <= 8'(event_idx);
         end else if (pitch_done) begin
            note_reg     <= rx_data[6:0];
            velocity_reg <= 7'd0;
            channel_reg  <= status_chan_reg;
         end
      end
   end

   assign note_pressed   = note_pressed_reg;
   assign note_released  = note_released_reg;
   assign note_keypress  = note_keypress_reg;
   assign pitch_wheel    = pitch_wheel_reg;
   assign voice_overflow = voice_overflow_reg;
   assign note           = note_reg;
   assign velocity       = velocity_reg;
   assign channel        = channel_reg;
   assign addr           = addr_reg;

endmodule

// File: tb/tb_midi_voice_alloc.sv
// Directed bench for midi_voice_alloc: parser, scan timing, allocation, overflow and reset.
module tb_midi_voice_alloc;
   localparam int NV = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       note_pressed, note_released, note_keypress, pitch_wheel, voice_overflow;
   logic [6:0] note, velocity;
   logic [3:0] channel;
   logic [7:0] addr;

   int check_cnt = 0;
   int pass_cnt  = 0;

   logic       obs_pressed, obs_released, obs_keypress, obs_pitch, obs_overflow;
   logic [6:0] obs_note, obs_vel;
   logic [3:0] obs_chan;
   logic [7:0] obs_addr;
   logic       ready_after;
   int         ready_low, pulse_cnt;

   midi_voice_alloc #(.NUM_VOICES(NV)) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .note_pressed(note_pressed), .note_released(note_released), .note_keypress(note_keypress),
      .pitch_wheel(pitch_wheel), .note(note), .velocity(velocity), .channel(channel),
      .addr(addr), .voice_overflow(voice_overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL global_timeout simulation still running");
      $fatal(1, "timeout");
   end

   task automatic do_reset();
      rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Returns #1 after the accepting edge, i.e. inside cycle T+1.
   task automatic send_byte(input logic [7:0] b);
      int waited = 0;
      @(negedge clk);
      while (!rx_ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (!rx_ready) begin
         check_cnt++;
         $display("FAIL send_timeout byte %h rx_ready got 0 want 1", b);
      end
      rx_data = b; rx_valid = 1'b1;
      @(posedge clk);
      #1 rx_valid = 1'b0;
   endtask

   // Watches cycles T+1..T+ncyc, snapshots outputs at T+ncyc, then samples rx_ready once more.
   task automatic observe(input int ncyc);
      ready_low = 0; pulse_cnt = 0;
      for (int k = 1; k <= ncyc; k++) begin
         @(negedge clk);
         if (!rx_ready) ready_low++;
         pulse_cnt += int'(note_pressed) + int'(note_released) + int'(note_keypress) +
                      int'(pitch_wheel) + int'(voice_overflow);
         if (k == ncyc) begin
            obs_pressed = note_pressed; obs_released = note_released;
            obs_keypress = note_keypress; obs_pitch = pitch_wheel; obs_overflow = voice_overflow;
            obs_note = note; obs_vel = velocity; obs_chan = channel; obs_addr = addr;
         end
      end
      @(negedge clk);
      ready_after = rx_ready;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      check_cnt++; if (rx_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", rx_ready); else pass_cnt++;
      check_cnt++; if ({note_pressed, note_released, note_keypress, pitch_wheel, voice_overflow} !== 5'b0)
         $display("FAIL reset_pulses got %b want 00000", {note_pressed, note_released, note_keypress, pitch_wheel, voice_overflow});
      else pass_cnt++;
      check_cnt++; if ({note, velocity, channel, addr} !== 26'd0)
         $display("FAIL reset_fields got %h want 0", {note, velocity, channel, addr}); else pass_cnt++;
   endtask

   task automatic test_press_basic();
      do_reset();
      send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
      observe(NV + 1);
      check_cnt++; if (ready_low !== NV + 1) $display("FAIL press_ready_low got %0d want %0d", ready_low, NV + 1); else pass_cnt++;
      check_cnt++; if (obs_pressed !== 1'b1) $display("FAIL press_pulse got %b want 1", obs_pressed); else pass_cnt++;
      check_cnt++; if (pulse_cnt !== 1) $display("FAIL press_pulse_count got %0d want 1", pulse_cnt); else pass_cnt++;
      check_cnt++; if ({obs_note, obs_vel, obs_chan, obs_addr} !== {7'h3C, 7'h64, 4'h0, 8'h00})
         $display("FAIL press_fields got %h/%h/%h/%h want 3c/64/0/00", obs_note, obs_vel, obs_chan, obs_addr);
      else pass_cnt++;
      check_cnt++; if (ready_after !== 1'b1) $display("FAIL press_ready_back got %b want 1", ready_after); else pass_cnt++;
   endtask

   task automatic test_running_status();
      do_reset();
      send_byte(8'h91); send_byte(8'h40); send_byte(8'h50);
      observe(NV + 1);
      check_cnt++; if ({obs_pressed, obs_chan, obs_addr} !== {1'b1, 4'h1, 8'h00})
         $display("FAIL rs_first got p=%b ch=%h a=%h want p=1 ch=1 a=00", obs_pressed, obs_chan, obs_addr); else pass_cnt++;
      send_byte(8'h41); send_byte(8'h50);
      observe(NV + 1);
      check_cnt++; if ({obs_pressed, obs_note, obs_addr} !== {1'b1, 7'h41, 8'h01})
         $display("FAIL rs_second got p=%b n=%h a=%h want p=1 n=41 a=01", obs_pressed, obs_note, obs_addr); else pass_cnt++;
      send_byte(8'h40); send_byte(8'h00);
      observe(NV + 1);
      check_cnt++; if ({obs_released, obs_pressed, obs_note, obs_vel, obs_addr} !== {1'b1, 1'b0, 7'h40, 7'h00, 8'h00})
         $display("FAIL rs_release got r=%b p=%b n=%h v=%h a=%h want r=1 p=0 n=40 v=00 a=00",
                  obs_released, obs_pressed, obs_note, obs_vel, obs_addr);
      else pass_cnt++;
      send_byte(8'h42); send_byte(8'h30);
      observe(NV + 1);
      check_cnt++; if ({obs_pressed, obs_note, obs_vel, obs_addr} !== {1'b1, 7'h42, 7'h30, 8'h00})
         $display("FAIL rs_reuse got p=%b n=%h v=%h a=%h want p=1 n=42 v=30 a=00", obs_pressed, obs_note, obs_vel, obs_addr);
      else pass_cnt++;
   endtask

   task automatic test_overflow();
      int bad = 0;
      do_reset();
      send_byte(8'h90);
      for (int i = 0; i < NV; i++) begin
         send_byte(8'(8'h3C + i)); send_byte(8'h40);
         observe(NV + 1);
         if (obs_pressed !== 1'b1 || obs_addr !== 8'(i)) begin
            bad++;
            $display("FAIL fill_slot_%0d got p=%b a=%h want p=1 a=%h", i, obs_pressed, obs_addr, 8'(i));
         end
      end
      check_cnt++; if (bad !== 0) $display("FAIL fill_slots bad got %0d want 0", bad); else pass_cnt++;
      send_byte(8'h4C); send_byte(8'h40);
      observe(NV + 1);
      check_cnt++; if ({obs_overflow, obs_pressed} !== 2'b10)
         $display("FAIL overflow_pulse got ov=%b p=%b want ov=1 p=0", obs_overflow, obs_pressed); else pass_cnt++;
      check_cnt++; if ({obs_note, obs_addr} !== {7'h4B, 8'h0F})
         $display("FAIL overflow_hold got n=%h a=%h want n=4b a=0f", obs_note, obs_addr); else pass_cnt++;
      send_byte(8'h3C); send_byte(8'h22);
      observe(NV + 1);
      check_cnt++; if ({obs_pressed, obs_overflow, obs_addr, obs_vel} !== {1'b1, 1'b0, 8'h00, 7'h22})
         $display("FAIL retrigger got p=%b ov=%b a=%h v=%h want p=1 ov=0 a=00 v=22",
                  obs_pressed, obs_overflow, obs_addr, obs_vel);
      else pass_cnt++;
   endtask

   task automatic test_pitch();
      do_reset();
      send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
      observe(NV + 1);
      send_byte(8'h91); send_byte(8'h3D); send_byte(8'h64);
      observe(NV + 1);
      send_byte(8'hE3); send_byte(8'h00); send_byte(8'h50);
      observe(1);
      check_cnt++; if ({obs_pitch, obs_note, obs_vel, obs_chan} !== {1'b1, 7'h50, 7'h00, 4'h3})
         $display("FAIL pitch_fields got pw=%b n=%h v=%h ch=%h want pw=1 n=50 v=00 ch=3",
                  obs_pitch, obs_note, obs_vel, obs_chan);
      else pass_cnt++;
      check_cnt++; if (obs_addr !== 8'h01) $display("FAIL pitch_addr_hold got %h want 01", obs_addr); else pass_cnt++;
      check_cnt++; if (ready_low !== 0 || ready_after !== 1'b1)
         $display("FAIL pitch_ready got low=%0d after=%b want low=0 after=1", ready_low, ready_after); else pass_cnt++;
   endtask

   task automatic test_realtime_system();
      do_reset();
      send_byte(8'h90); send_byte(8'h3E); send_byte(8'h10);
      observe(NV + 1);
      send_byte(8'h90); send_byte(8'h3C); send_byte(8'hF8); send_byte(8'h64);
      observe(NV + 1);
      check_cnt++; if ({obs_pressed, obs_note, obs_vel, obs_addr} !== {1'b1, 7'h3C, 7'h64, 8'h01})
         $display("FAIL realtime_press got p=%b n=%h v=%h a=%h want p=1 n=3c v=64 a=01",
                  obs_pressed, obs_note, obs_vel, obs_addr);
      else pass_cnt++;
      send_byte(8'h90); send_byte(8'h3D); send_byte(8'hF0); send_byte(8'h64);
      observe(NV + 1);
      check_cnt++; if (pulse_cnt !== 0 || ready_low !== 0)
         $display("FAIL sysex_discard got pulses=%0d low=%0d want 0/0", pulse_cnt, ready_low); else pass_cnt++;
      send_byte(8'hA0); send_byte(8'h3C); send_byte(8'h20);
      observe(NV + 1);
      check_cnt++; if ({obs_keypress, obs_vel, obs_addr, obs_note} !== {1'b1, 7'h20, 8'h01, 7'h3C})
         $display("FAIL keypress got k=%b v=%h a=%h n=%h want k=1 v=20 a=01 n=3c",
                  obs_keypress, obs_vel, obs_addr, obs_note);
      else pass_cnt++;
      send_byte(8'h3F); send_byte(8'h20);
      observe(NV + 1);
      check_cnt++; if (pulse_cnt !== 0 || ready_low !== NV + 1)
         $display("FAIL keypress_nomatch got pulses=%0d low=%0d want 0/%0d", pulse_cnt, ready_low, NV + 1);
      else pass_cnt++;
   endtask

   task automatic test_reset_midscan();
      do_reset();
      send_byte(8'h95); send_byte(8'h3C); send_byte(8'h64);
      observe(NV + 1);
      send_byte(8'h3E); send_byte(8'h64);
      observe(NV + 1);
      send_byte(8'h3D); send_byte(8'h64);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_cnt++; if ({note, velocity, channel, addr} !== 26'd0)
         $display("FAIL midscan_fields got %h want 0", {note, velocity, channel, addr}); else pass_cnt++;
      check_cnt++; if (rx_ready !== 1'b1) $display("FAIL midscan_ready got %b want 1", rx_ready); else pass_cnt++;
      observe(NV + 4);
      check_cnt++; if (pulse_cnt !== 0) $display("FAIL midscan_no_pulse got %0d want 0", pulse_cnt); else pass_cnt++;
      send_byte(8'h85); send_byte(8'h3C); send_byte(8'h40);
      observe(NV + 1);
      check_cnt++; if (pulse_cnt !== 0) $display("FAIL midscan_table_cleared got %0d pulses want 0", pulse_cnt); else pass_cnt++;
   endtask

   initial begin
      rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
      test_reset();
      test_press_basic();
      test_running_status();
      test_overflow();
      test_pitch();
      test_realtime_system();
      test_reset_midscan();
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end
endmodule
